mem_arbiter: RTL and testbench

- Shares the single-port program/data RAM between the processor and a host loader port.
- The processor side is driven by the sequencer's CS/R_NW/address/data. The host side is used to load ciphertext/program and to read back results while the CPU runs.
- Two-way round-robin arbitration, one access at a time. Registered memory-port outputs.
- Stalls the CPU through `cpu_wait` until its access completes.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/rr_pick2.sv | 19 +
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the program/data RAM arbiter.
//   arb_state_e : arbiter FSM states (idle, access cycle, completion cycle per requester)
//   requester_e : identity of a requester, used to remember the last grant
package mem_arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAccCpu,
        StAccHost,
        StDoneCpu,
        StDoneHost
    } arb_state_e;

    typedef enum logic {
        ReqCpu  = 1'b0,
        ReqHost = 1'b1
    } requester_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
//   req_a, req_b : requests
//   last         : requester granted most recently (0 = a, 1 = b)
//   gnt_a, gnt_b : one-hot (or zero) grant
// A lone request always wins; on a tie the side that was not granted last wins.
module rr_pick2 (
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    output logic gnt_a,
    output logic gnt_b
);

    always_comb begin
        gnt_a = req_a & (~req_b | last);
        gnt_b = req_b & (~req_a | ~last);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port program/data RAM between the CPU sequencer and the
// host loader. One access at a time, round-robin on contention, registered RAM port.
//   clock, n_reset                     : clock and asynchronous active-low reset
//   cpu_cs/r_nw/addr/wdata             : CPU request (held until cpu_valid)
//   cpu_rdata, cpu_valid, cpu_wait     : CPU read data, completion pulse, stall
//   host_req/r_nw/addr/wdata           : host request (held until host_ack)
//   host_rdata, host_ack               : host read data, completion pulse
//   mem_cs/r_nw/addr/wdata, mem_rdata  : RAM port
// Each access takes IDLE (grant) -> ACC (mem_cs high) -> DONE (valid/ack) -> IDLE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned WORD_W = 10,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clock,
    input  logic              n_reset,

    input  logic              cpu_cs,
    input  logic              cpu_r_nw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic [WORD_W-1:0] cpu_rdata,
    output logic              cpu_valid,
    output logic              cpu_wait,

    input  logic              host_req,
    input  logic              host_r_nw,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [WORD_W-1:0] host_wdata,
    output logic [WORD_W-1:0] host_rdata,
    output logic              host_ack,

    output logic              mem_cs,
    output logic              mem_r_nw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    arb_state_e        state_q, state_d;
    requester_e        last_q, last_d;
    logic              mem_cs_q, mem_cs_d;
    logic              mem_r_nw_q, mem_r_nw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_valid_q, cpu_valid_d;
    logic              host_ack_q, host_ack_d;
    logic [WORD_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [WORD_W-1:0] host_rdata_q, host_rdata_d;

    logic gnt_cpu, gnt_host;

    rr_pick2 u_pick (
        .req_a (cpu_cs),
        .req_b (host_req),
        .last  (last_q == ReqHost),
        .gnt_a (gnt_cpu),
        .gnt_b (gnt_host)
    );

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        mem_cs_d     = 1'b0;
        mem_r_nw_d   = mem_r_nw_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_valid_d  = 1'b0;
        host_ack_d   = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        host_rdata_d = host_rdata_q;

        case (state_q)
            StIdle: begin
                // Requests are only looked at here; the access parameters are frozen at grant.
                if (gnt_cpu) begin
                    state_d     = StAccCpu;
                    last_d      = ReqCpu;
                    mem_cs_d    = 1'b1;
                    mem_r_nw_d  = cpu_r_nw;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                end else if (gnt_host) begin
                    state_d     = StAccHost;
                    last_d      = ReqHost;
                    mem_cs_d    = 1'b1;
                    mem_r_nw_d  = host_r_nw;
                    mem_addr_d  = host_addr;
                    mem_wdata_d = host_wdata;
                end
            end
            StAccCpu: begin
                state_d     = StDoneCpu;
                cpu_valid_d = 1'b1;
                if (mem_r_nw_q) begin
                    cpu_rdata_d = mem_rdata;
                end
            end
            StAccHost: begin
                state_d    = StDoneHost;
                host_ack_d = 1'b1;
                if (mem_r_nw_q) begin
                    host_rdata_d = mem_rdata;
                end
            end
            StDoneCpu,
            StDoneHost: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= StIdle;
            last_q       <= ReqHost;
            mem_cs_q     <= 1'b0;
            mem_r_nw_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_valid_q  <= 1'b0;
            host_ack_q   <= 1'b0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            mem_cs_q     <= mem_cs_d;
            mem_r_nw_q   <= mem_r_nw_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_valid_q  <= cpu_valid_d;
            host_ack_q   <= host_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign mem_cs     = mem_cs_q;
    assign mem_r_nw   = mem_r_nw_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_valid  = cpu_valid_q;
    assign host_ack   = host_ack_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign host_rdata = host_rdata_q;

    // Sequencer stall: pending CPU access not yet completed.
    assign cpu_wait = cpu_cs & ~cpu_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small RAM model on the memory port.
module tb_mem_arbiter;

    localparam int unsigned WORD_W = 10;
    localparam int unsigned ADDR_W = 7;

    logic              clock = 1'b0;
    logic              n_reset = 1'b0;
    logic              cpu_cs = 1'b0, cpu_r_nw = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [WORD_W-1:0] cpu_wdata = '0;
    logic [WORD_W-1:0] cpu_rdata;
    logic              cpu_valid, cpu_wait;
    logic              host_req = 1'b0, host_r_nw = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [WORD_W-1:0] host_wdata = '0;
    logic [WORD_W-1:0] host_rdata;
    logic              host_ack;
    logic              mem_cs, mem_r_nw;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;

    logic [WORD_W-1:0] ram [2**ADDR_W];

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .n_reset    (n_reset),
        .cpu_cs     (cpu_cs),
        .cpu_r_nw   (cpu_r_nw),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_valid  (cpu_valid),
        .cpu_wait   (cpu_wait),
        .host_req   (host_req),
        .host_r_nw  (host_r_nw),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .host_ack   (host_ack),
        .mem_cs     (mem_cs),
        .mem_r_nw   (mem_r_nw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // RAM model: read word presented while mem_cs is high, captured by the arbiter at the
    // edge that ends that cycle; writes land at the same edge.
    assign mem_rdata = ram[mem_addr];
    always @(posedge clock) begin
        if (mem_cs && !mem_r_nw) ram[mem_addr] <= mem_wdata;
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    logic [7:0] ord [8];
    logic [7:0] exp_ord [6];
    int n_ord;
    int first_host;
    int ack_t [4];
    int n_ack;

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) ram[i] = '0;
        ram[5] = 10'h155;
        ram[1] = 10'h0A1;
        ram[2] = 10'h1B2;
        ram[3] = 10'h0C3;

        // Reset state
        tick();
        check("rst_mem_cs", 32'(mem_cs), 0);
        check("rst_mem_r_nw", 32'(mem_r_nw), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_cpu_valid", 32'(cpu_valid), 0);
        check("rst_host_ack", 32'(host_ack), 0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 0);
        check("rst_host_rdata", 32'(host_rdata), 0);
        check("rst_cpu_wait", 32'(cpu_wait), 0);
        n_reset = 1'b1;
        tick();

        // CPU read alone
        cpu_cs = 1'b1; cpu_r_nw = 1'b1; cpu_addr = 7'h05;
        #1 check("rd_wait0", 32'(cpu_wait), 1);
        check("rd_cs0", 32'(mem_cs), 0);
        tick();
        check("rd_cs1", 32'(mem_cs), 1);
        check("rd_rnw1", 32'(mem_r_nw), 1);
        check("rd_addr1", 32'(mem_addr), 32'h05);
        check("rd_wait1", 32'(cpu_wait), 1);
        check("rd_valid1", 32'(cpu_valid), 0);
        tick();
        check("rd_valid2", 32'(cpu_valid), 1);
        check("rd_data2", 32'(cpu_rdata), 32'h155);
        check("rd_wait2", 32'(cpu_wait), 0);
        check("rd_cs2", 32'(mem_cs), 0);
        cpu_cs = 1'b0;
        tick();
        check("rd_valid3", 32'(cpu_valid), 0);
        check("rd_cs3", 32'(mem_cs), 0);
        check("rd_data3", 32'(cpu_rdata), 32'h155);

        // Host write then CPU read of the same address
        host_req = 1'b1; host_r_nw = 1'b0; host_addr = 7'h10; host_wdata = 10'h2AA;
        tick();
        check("hw_cs", 32'(mem_cs), 1);
        check("hw_rnw", 32'(mem_r_nw), 0);
        check("hw_wdata", 32'(mem_wdata), 32'h2AA);
        tick();
        check("hw_ack", 32'(host_ack), 1);
        check("hw_rdata", 32'(host_rdata), 0);
        host_req = 1'b0;
        tick();
        check("hw_ram", 32'(ram[16]), 32'h2AA);
        cpu_cs = 1'b1; cpu_r_nw = 1'b1; cpu_addr = 7'h10;
        tick();
        tick();
        check("cr_valid", 32'(cpu_valid), 1);
        check("cr_data", 32'(cpu_rdata), 32'h2AA);
        cpu_cs = 1'b0;
        tick();

        // Sustained contention from reset
        n_reset = 1'b0;
        tick();
        n_reset = 1'b1;
        tick();
        exp_ord[0] = "C"; exp_ord[1] = "H"; exp_ord[2] = "C";
        exp_ord[3] = "H"; exp_ord[4] = "C"; exp_ord[5] = "H";
        n_ord = 0;
        first_host = -1;
        cpu_cs = 1'b1; cpu_r_nw = 1'b1; cpu_addr = 7'h01;
        host_req = 1'b1; host_r_nw = 1'b1; host_addr = 7'h02;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (cpu_valid && n_ord < 8) begin ord[n_ord] = "C"; n_ord++; end
            if (host_ack && n_ord < 8) begin ord[n_ord] = "H"; n_ord++; end
            if (host_ack && first_host < 0) first_host = t;
            if (t == 17) begin cpu_cs = 1'b0; host_req = 1'b0; end
        end
        check("ct_count", 32'(n_ord), 6);
        for (int i = 0; i < 6; i++) check("ct_order", 32'(ord[i]), 32'(exp_ord[i]));
        check("ct_host_lat", 32'(first_host), 5);
        check("ct_cpu_data", 32'(cpu_rdata), 32'h0A1);
        check("ct_host_data", 32'(host_rdata), 32'h1B2);

        // Held host request: two accesses three cycles apart
        n_ack = 0;
        host_req = 1'b1; host_r_nw = 1'b1; host_addr = 7'h03;
        for (int t = 1; t <= 9; t++) begin
            tick();
            if (host_ack && n_ack < 4) begin ack_t[n_ack] = t; n_ack++; end
            if (t == 5) host_req = 1'b0;
        end
        check("hold_count", 32'(n_ack), 2);
        check("hold_gap", 32'(ack_t[1] - ack_t[0]), 3);
        check("hold_data", 32'(host_rdata), 32'h0C3);

        // Host request dropped before grant while CPU busy
        n_ack = 0;
        cpu_cs = 1'b1; cpu_r_nw = 1'b1; cpu_addr = 7'h05;
        tick();
        host_req = 1'b1; host_r_nw = 1'b0; host_addr = 7'h11; host_wdata = 10'h111;
        tick();
        check("drop_cvalid", 32'(cpu_valid), 1);
        cpu_cs = 1'b0; host_req = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            if (host_ack || mem_cs) n_ack++;
        end
        check("drop_no_host", 32'(n_ack), 0);
        check("drop_ram", 32'(ram[17]), 0);

        // CPU write at the top address
        cpu_cs = 1'b1; cpu_r_nw = 1'b0; cpu_addr = 7'h7F; cpu_wdata = 10'h3FF;
        tick();
        check("wr_cs", 32'(mem_cs), 1);
        check("wr_rnw", 32'(mem_r_nw), 0);
        check("wr_addr", 32'(mem_addr), 32'h7F);
        check("wr_wdata", 32'(mem_wdata), 32'h3FF);
        tick();
        check("wr_valid", 32'(cpu_valid), 1);
        check("wr_rdata_kept", 32'(cpu_rdata), 32'h155);
        check("wr_cs_off", 32'(mem_cs), 0);
        cpu_cs = 1'b0;
        tick();
        check("wr_ram", 32'(ram[127]), 32'h3FF);

        // Reset while the host access is in ACC
        host_req = 1'b1; host_r_nw = 1'b0; host_addr = 7'h14; host_wdata = 10'h123;
        tick();
        check("ra_cs_before", 32'(mem_cs), 1);
        #2 n_reset = 1'b0;
        #1 check("ra_cs_async", 32'(mem_cs), 0);
        host_req = 1'b0;
        n_ack = 0;
        for (int t = 0; t < 2; t++) begin
            tick();
            if (host_ack) n_ack++;
        end
        check("ra_no_ack", 32'(n_ack), 0);
        check("ra_ram", 32'(ram[20]), 0);
        n_reset = 1'b1;
        tick();
        cpu_cs = 1'b1; cpu_r_nw = 1'b1; cpu_addr = 7'h05;
        host_req = 1'b1; host_r_nw = 1'b1; host_addr = 7'h02;
        tick();
        tick();
        check("ra_tie_cpu", 32'(cpu_valid), 1);
        check("ra_tie_host", 32'(host_ack), 0);
        cpu_cs = 1'b0;
        tick();
        tick();
        tick();
        check("ra_host_next", 32'(host_ack), 1);
        host_req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
